// File: rtl/vx_raster_stamp_arb_if.sv
// Stamp type definitions and the slice-to-shader handshake bundle used by
// the raster stamp arbiter.
package vx_raster_types;
    typedef struct packed {
        logic [11:0] pos_x;
        logic [11:0] pos_y;
        logic [3:0]  mask;
        logic [7:0]  pid;
    } raster_stamp_t;
endpackage

interface vx_raster_stamp_arb_if #(
    parameter int NUM_INPUTS = 4,
    parameter int STAMP_BITS = $bits(vx_raster_types::raster_stamp_t),
    parameter int LOG_NUM    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
);
    logic [NUM_INPUTS-1:0]                 in_valid;
    logic [NUM_INPUTS-1:0][STAMP_BITS-1:0] in_data;
    logic [NUM_INPUTS-1:0]                 in_done;
    logic [NUM_INPUTS-1:0]                 in_ready;
    logic                                  out_valid;
    logic [STAMP_BITS-1:0]                 out_data;
    logic [LOG_NUM-1:0]                    out_src;
    logic                                  out_ready;

    modport slave (
        input  in_valid, in_data, in_done, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport master (
        output in_valid, in_data, in_done, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/vx_raster_stamp_arb.sv
// Round-robin merge of per-slice raster stamps into one registered stream,
// with frame tracking (IDLE/RUN/DRAIN), done pulse and delivered-stamp count.
module vx_raster_stamp_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int STAMP_BITS = $bits(vx_raster_types::raster_stamp_t),
    parameter int LOG_NUM    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    vx_raster_stamp_arb_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stamp_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [LOG_NUM-1:0] rr_ptr;
    logic [LOG_NUM-1:0] grant_idx;
    logic [LOG_NUM-1:0] next_ptr;
    logic               grant_any;
    logic               can_load;
    logic               accept;
    logic               all_done;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_INPUTS;
            if (!grant_any && bus.in_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = LOG_NUM'(idx);
            end
        end
    end

    // The output register may reload in the same cycle it is drained.
    assign can_load = !bus.out_valid || bus.out_ready;
    assign accept   = (state == RUN) && grant_any && can_load;
    assign all_done = (&bus.in_done) && !(|bus.in_valid);
    assign next_ptr = (grant_idx == LOG_NUM'(NUM_INPUTS - 1)) ? '0 : grant_idx + LOG_NUM'(1);

    always_comb begin
        bus.in_ready = '0;
        if (accept) bus.in_ready[grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            stamp_count   <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            done <= 1'b0;

            if (bus.out_valid && bus.out_ready) stamp_count <= stamp_count + 32'd1;

            if (accept) begin
                rr_ptr        <= next_ptr;
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[grant_idx];
                bus.out_src   <= grant_idx;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case (state)
                IDLE: if (start) begin
                    state       <= RUN;
                    busy        <= 1'b1;
                    rr_ptr      <= '0;
                    stamp_count <= '0;
                end
                RUN: if (all_done) state <= DRAIN;
                // No loads happen in DRAIN, so can_load means the register is empty after this edge.
                DRAIN: if (can_load) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_raster_stamp_arb.sv
// Self-checking bench for vx_raster_stamp_arb: directed vector table, hand
// sequences for reset/wrap/done corners, and randomized traffic vs a model.
module tb_vx_raster_stamp_arb;
    import vx_raster_types::*;

    localparam int N  = 4;
    localparam int SB = $bits(raster_stamp_t);
    localparam int LG = 2;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] stamp_count;

    vx_raster_stamp_arb_if #(.NUM_INPUTS(N), .STAMP_BITS(SB), .LOG_NUM(LG)) bus ();

    vx_raster_stamp_arb #(.NUM_INPUTS(N), .STAMP_BITS(SB), .LOG_NUM(LG)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .stamp_count(stamp_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: frame phase, pointer, a queue standing in for the output buffer.
    typedef struct {
        logic [SB-1:0] data;
        int            src;
    } item_t;

    item_t       m_buf[$];
    int          m_phase = P_IDLE;
    int          m_ptr   = 0;
    logic [31:0] m_cnt   = '0;
    bit          m_done  = 1'b0;
    bit          m_known = 1'b0;
    logic [N-1:0] seen_ready;

    function automatic int pick(input logic [N-1:0] iv, input bit ordy);
        if (m_phase != P_RUN) return -1;
        if (m_buf.size() != 0 && !ordy) return -1;
        for (int k = 0; k < N; k++)
            if (iv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge(input bit st, input logic [N-1:0] iv, input logic [N-1:0] dn,
                              input bit ordy, input bit rn, input int g,
                              input logic [N-1:0][SB-1:0] d);
        item_t it;
        if (!rn) begin
            m_phase = P_IDLE;
            m_ptr   = 0;
            m_buf.delete();
            m_cnt   = '0;
            m_done  = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_buf.size() != 0 && ordy) begin
            it    = m_buf.pop_front();
            m_cnt = m_cnt + 32'd1;
        end
        if (g >= 0) begin
            it.data = d[g];
            it.src  = g;
            m_buf.push_back(it);
            m_ptr = (g + 1) % N;
        end
        case (m_phase)
            P_IDLE:  if (st) begin m_phase = P_RUN; m_ptr = 0; m_cnt = '0; end
            P_RUN:   if (dn == '1 && iv == '0) m_phase = P_DRAIN;
            default: if (m_buf.size() == 0) begin m_phase = P_IDLE; m_done = 1'b1; end
        endcase
    endtask

    task automatic step(input bit st, input logic [N-1:0] iv, input logic [N-1:0] dn,
                        input bit ordy, input bit rn);
        int g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0][SB-1:0] d;
        @(negedge clk);
        reset = rn;
        start = st;
        bus.in_valid  = iv;
        bus.in_done   = dn;
        bus.out_ready = ordy;
        for (int s = 0; s < N; s++) d[s] = SB'({$urandom(), $urandom()});
        bus.in_data = d;
        #1;
        g = pick(iv, ordy);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        seen_ready = bus.in_ready;
        if (m_known) check("in_ready", bus.in_ready, exp_rdy);
        @(posedge clk);
        model_edge(st, iv, dn, ordy, rn, g, d);
        m_known = 1'b1;
        #1;
        check("out_valid", bus.out_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            check("out_data", bus.out_data, m_buf[0].data);
            check("out_src", bus.out_src, m_buf[0].src);
        end
        check("busy", busy, m_phase != P_IDLE);
        check("done", done, m_done);
        check("stamp_count", stamp_count, m_cnt);
    endtask

    typedef struct {
        bit          st;
        logic [3:0]  iv;
        logic [3:0]  dn;
        bit          ordy;
        logic [3:0]  e_ready;
        bit          e_ov;
        logic [1:0]  e_src;
        bit          e_busy;
        bit          e_done;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset = 1'b0;
        start = 1'b0;
        bus.in_valid  = '0;
        bus.in_done   = '0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;

        // Single-source frame, drain/done, then fairness, backpressure and delayed drain.
        //            st  iv     dn     ordy  ready  ov  src  busy done cnt
        vecs.push_back('{1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 4'h1, 4'h0, 1, 4'h1, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 4'h1, 4'h0, 1, 4'h1, 1, 0, 1, 0, 1});
        vecs.push_back('{0, 4'h1, 4'h0, 1, 4'h1, 1, 0, 1, 0, 2});
        vecs.push_back('{0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 1, 0, 3});
        vecs.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 1, 0, 3});
        vecs.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 1, 3});
        vecs.push_back('{0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 3});
        vecs.push_back('{1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 1, 0, 1});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h4, 1, 2, 1, 0, 2});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h8, 1, 3, 1, 0, 3});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 1, 0, 4});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 1, 0, 5});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h4, 1, 2, 1, 0, 6});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h8, 1, 3, 1, 0, 7});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{0, 4'hF, 4'h0, 0, 4'h0, 1, 3, 1, 0, 7});
        vecs.push_back('{0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 1, 0, 8});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{0, 4'h0, 4'hF, 0, 4'h0, 1, 0, 1, 0, 8});
        vecs.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 1, 9});
        vecs.push_back('{0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 9});

        // Reset state.
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 0, 0);
        check("rst_in_ready", bus.in_ready, 4'h0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_src", bus.out_src, '0);

        foreach (vecs[i]) begin
            v = vecs[i];
            step(v.st, v.iv, v.dn, v.ordy, 1);
            check($sformatf("vec%0d_ready", i), seen_ready, v.e_ready);
            check($sformatf("vec%0d_ov", i), bus.out_valid, v.e_ov);
            if (v.e_ov) check($sformatf("vec%0d_src", i), bus.out_src, v.e_src);
            check($sformatf("vec%0d_busy", i), busy, v.e_busy);
            check($sformatf("vec%0d_done", i), done, v.e_done);
            check($sformatf("vec%0d_cnt", i), stamp_count, v.e_cnt);
        end

        // Reset mid-frame with a buffered stamp, then a clean restart.
        step(1, 4'h0, 4'h0, 0, 1);
        step(0, 4'h1, 4'h0, 0, 1);
        step(1, 4'h0, 4'h0, 0, 1);
        check("midrst_ov_before", bus.out_valid, 1'b1);
        step(0, 4'h2, 4'h0, 0, 0);
        check("midrst_ov", bus.out_valid, 1'b0);
        check("midrst_data", bus.out_data, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cnt", stamp_count, 32'd0);
        step(0, 4'h2, 4'h0, 1, 1);
        check("idle_after_rst_ready", seen_ready, 4'h0);
        step(1, 4'h0, 4'h0, 1, 1);
        step(0, 4'h2, 4'h0, 1, 1);
        step(0, 4'h0, 4'h0, 1, 1);
        check("restart_cnt", stamp_count, 32'd1);

        // Counter wrap.
        force dut.stamp_count = 32'hFFFF_FFFF;
        #1;
        release dut.stamp_count;
        m_cnt = 32'hFFFF_FFFF;
        step(0, 4'h4, 4'h0, 1, 1);
        step(0, 4'h0, 4'h0, 1, 1);
        check("wrap_cnt", stamp_count, 32'd0);
        step(0, 4'h0, 4'hF, 1, 1);
        step(0, 4'h0, 4'hF, 1, 1);
        check("wrap_done", done, 1'b1);

        // A stamp offered together with in_done is still taken before DRAIN.
        step(1, 4'h0, 4'h0, 1, 1);
        step(0, 4'h8, 4'hF, 1, 1);
        check("valid_with_done_ready", seen_ready, 4'h8);
        step(0, 4'h0, 4'hF, 1, 1);
        step(0, 4'h0, 4'hF, 1, 1);
        check("valid_with_done_done", done, 1'b1);
        check("valid_with_done_cnt", stamp_count, 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bit          r_st;
            bit          r_rn;
            bit          r_ordy;
            logic [N-1:0] r_iv;
            logic [N-1:0] r_dn;
            r_st   = ($urandom_range(0, 15) == 0);
            r_rn   = ($urandom_range(0, 299) != 0);
            r_ordy = ($urandom_range(0, 3) != 0);
            r_iv   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom());
            r_dn   = ($urandom_range(0, 9) < 3) ? '1 : N'($urandom());
            step(r_st, r_iv, r_dn, r_ordy, r_rn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vx_raster_stamp_arb.md
VX_RASTER_STAMP_ARB -- requirements
Module: VX_raster_stamp_arb

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of rasterizer slices feeding stamps (range 1..16).
REQ-002 SHALL have parameter STAMP_BITS, default $bits(VX_raster_types::raster_stamp_t), width of one stamp word.
REQ-003 SHALL have parameter LOG_NUM = `CLOG2(NUM_INPUTS) (min 1), the grant index width.
REQ-004 SHALL have port `clk` as an input, 1 bit: the single clock.
REQ-005 SHALL have port `reset` as an input, 1 bit: the synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 SHALL have port `start` as an input, 1 bit: a one-cycle pulse that begins a frame after DCRs are written.
REQ-007 SHALL have port `in_valid` as an input, NUM_INPUTS bits: per-slice stamp valid.
REQ-008 SHALL have port `in_data` as an input, NUM_INPUTS x STAMP_BITS: per-slice raster_stamp_t.
REQ-009 SHALL have port `in_done` as an input, NUM_INPUTS bits: a level that means the slice has emitted its last stamp of the frame.
REQ-010 SHALL have port `in_ready` as an output, NUM_INPUTS bits: per-slice accept.
REQ-011 SHALL have port `out_valid` as an output, 1 bit: stamp available to the shader path.
REQ-012 SHALL have port `out_data` as an output, STAMP_BITS: the granted stamp.
REQ-013 SHALL have port `out_src` as an output, LOG_NUM bits: the index of the slice that produced out_data.
REQ-014 SHALL have port `out_ready` as an input, 1 bit: the downstream accept.
REQ-015 SHALL have port `busy` as an output, 1 bit: a frame is in progress.
REQ-016 SHALL have port `done` as an output, 1 bit: the frame has fully drained.
REQ-017 SHALL have port `stamp_count` as an output, 32 bits: the number of stamps delivered this frame.

Function
REQ-018 SHALL implement states IDLE, RUN and DRAIN in a registered FSM.
REQ-019 SHALL make the following transitions:
- IDLE -> RUN on start.
- RUN -> DRAIN when all in_done = 1 and in_valid = 0.
- DRAIN -> IDLE when the output register is empty, or is accepted this cycle; done pulses for 1 cycle on this transition.
REQ-020 SHALL ignore start in RUN and DRAIN (no restart mid-frame).
REQ-021 SHALL hold in_ready at all-zero in IDLE and DRAIN, so that stamps offered outside a frame stall.
REQ-022 SHALL arbitrate in RUN with a round-robin grant among asserted in_valid bits, searching from index rr_ptr upward with wrap from NUM_INPUTS-1 to 0.
REQ-023 SHALL set in_ready[g] = 1 only for the granted index g, and only when the output register can load (out_valid = 0 or out_ready = 1).
REQ-024 SHALL set rr_ptr <= (g + 1) mod NUM_INPUTS on every accepted input transfer; rr_ptr SHALL otherwise hold.
REQ-025 SHALL reset rr_ptr to 0 on start.
REQ-026 SHALL register out_data and out_src on an accepted input transfer, so that an accepted stamp appears on out_valid exactly 1 cycle later.
REQ-027 SHALL hold out_valid, out_data and out_src stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL sustain full throughput: a simultaneous out_ready = 1 and a new grant reloads the register the same cycle, giving 1 stamp/cycle.
REQ-029 SHALL increment stamp_count by 1 on each out_valid & out_ready cycle.
REQ-030 SHALL clear stamp_count to 0 on start in IDLE.
REQ-031 SHALL wrap stamp_count from 0xFFFFFFFF to 0.
REQ-032 SHALL hold stamp_count after done until the next start.
REQ-033 SHALL drive busy = 1 in RUN and DRAIN, and busy = 0 in IDLE.
REQ-034 SHALL treat in_valid asserted together with in_done on the same slice as a valid stamp; the frame SHALL NOT enter DRAIN until that stamp is accepted.
REQ-035 SHALL never grant more than one input per cycle, and in_ready SHALL be one-hot or zero.

Reset
REQ-036 SHALL, when reset = 0 at a clock edge, force state = IDLE, rr_ptr = 0, out_valid = 0, out_data = 0, out_src = 0, stamp_count = 0, done = 0 and busy = 0.
REQ-037 SHALL abandon any frame in progress when reset is asserted mid-frame, losing any buffered stamp.
REQ-038 SHALL take effect from the first edge with reset = 1 again; the next start SHALL begin a new frame normally.
REQ-039 SHALL make in_ready combinationally 0 while the state is IDLE, which includes the cycle after reset.

Verification
REQ-040 SHALL verify single-source flow: NUM_INPUTS = 4, start, then in_valid = 0001 for 3 stamps with out_ready = 1 -> out_valid 1 cycle after each acceptance, out_src = 0, stamp_count = 3.
REQ-041 SHALL verify fairness: in_valid = 1111 held for 8 cycles with out_ready = 1 -> grant order 0,1,2,3,0,1,2,3 and out_src matching that order.
REQ-042 SHALL verify backpressure: out_valid = 1 with out_ready = 0 for 5 cycles -> out_data stable, in_ready = 0000, rr_ptr unchanged; out_ready = 1 -> next grant on the same cycle.
REQ-043 SHALL verify drain and done: all in_done = 1 with one stamp still buffered and out_ready delayed 3 cycles -> DRAIN held, done pulses exactly once on acceptance, then busy = 0.
REQ-044 SHALL verify reset mid-frame: reset = 0 for 1 cycle while out_valid = 1 -> all outputs zero next cycle, a subsequent start restarts stamp_count from 0.
REQ-045 SHALL verify wrap: stamp_count forced to 0xFFFFFFFF, then one delivery -> stamp_count = 0.
